operand_add_sequencer: RTL and testbench
========================================

// Module: operand_add_sequencer
// PURPOSE
//  Sits directly downstream of rx_module. Captures two successive 381-bit operands
//  (A then B) from rx_module's RxData on each rising edge of its done flag.
//  Adds them bit-serially by slice (multi-cycle, carry-chained) and presents a
//  382-bit sum to the transmit side with a valid/ready handshake.
// PARAMETERS
//  WIDTH           381   operand width in bits
//  SLICE           64    adder slice width per cycle
//  TIMEOUT_CYCLES  2**24 max clk cycles in WAIT_B (used only with ADDER_TIMEOUT_EN)
// PORTS
//  clk        in   1        system clock (same clk as rx_module)
//  reset      in   1        synchronous, active-high reset
//  rx_data    in   WIDTH    operand word from rx_module.RxData
//  rx_done    in   1        rx_module.done (level); rising edge = operand complete
//  sum        out  WIDTH+1  A+B, bit WIDTH = carry out
//  sum_valid  out  1        sum is stable and valid
//  sum_ready  in   1        consumer accepts sum when high with sum_valid
//  busy       out  1        high in ADD and HOLD
//  overrun    out  1        1-cycle pulse: operand edge arrived while busy (dropped)
//  timeout    out  1        1-cycle pulse on WAIT_B expiry (ADDER_TIMEOUT_EN only, else 0)
// BEHAVIOUR
//  - Reset: state=WAIT_A; sum=0, sum_valid=0, busy=0, overrun=0, timeout=0;
//    A/B regs, carry, slice index, edge-detect register cleared. Reset mid-ADD/HOLD aborts, no output.
//  - Edge detect: done_q <= rx_done each cycle; edge = rx_done & ~done_q.
//  - SLICES = ceil(WIDTH/SLICE) (6 at defaults); operands zero-extended to SLICES*SLICE.
//  - WAIT_A: on edge, A <= rx_data -> WAIT_B.
//  - WAIT_B: on edge, B <= rx_data, carry<=0, idx<=0 -> ADD.
//  - ADD: per cycle {carry, S[idx]} = A[idx]+B[idx]+carry; idx++; after slice
//    SLICES-1 -> HOLD with sum = {carry_final, S[WIDTH-1:0]}, sum_valid=1.
//  - Latency: sum_valid rises exactly SLICES+1 cycles after the B-capture cycle.
//  - HOLD: sum and sum_valid held stable until sum_valid&sum_ready; that cycle
//    sum_valid drops next clock, state -> WAIT_A. sum retains last value.
//  - sum_ready ignored outside HOLD. No combinational path sum_ready -> sum_valid.
//  - Edge while in ADD or HOLD: operand dropped, overrun pulses 1 cycle, state unaffected.
//  - Edge in same cycle as HOLD acceptance: treated as busy -> dropped + overrun.
//  - Arithmetic unsigned; no overflow possible (sum is WIDTH+1 bits).
// CONFIGURATION
//  ADDER_TIMEOUT_EN defined: 32-bit counter runs in WAIT_B, cleared on entry;
//    reaching TIMEOUT_CYCLES without an edge -> discard A, pulse timeout, -> WAIT_A.
//    Edge in the expiry cycle wins (B captured, no timeout).
//  Undefined: no counter; WAIT_B waits indefinitely; timeout tied 0.
// STRUCTURE
//  Package adder_pkg: WIDTH, SLICE, SLICES localparams; state enum
//    {WAIT_A, WAIT_B, ADD, HOLD}; slice index type ($clog2(SLICES) bits).
//  Sub-module slice_adder (SLICE-bit a+b+cin -> {cout,s}, combinational),
//    instantiated once; FSM, operand/sum regs and edge detect in top.
// TESTING
//  1. A=1, B=2 via rx_done edges -> sum=3, sum_valid after SLICES+1 cycles.
//  2. A=2**381-1, B=1 -> sum=2**381 (bit 381 set, rest 0).
//  3. A=2**64-1, B=1 -> sum=2**64 (carry across slice 0/1 boundary).
//  4. sum_ready low 10 cycles in HOLD, rx_done edge injected -> sum stable,
//     overrun pulses once, next accepted operand treated as new A.
//  5. reset asserted mid-ADD -> next cycle sum_valid=0, state WAIT_A; A=5,B=7 -> 12.
//  6. ADDER_TIMEOUT_EN, TIMEOUT_CYCLES=100: A only -> timeout pulse at cycle 100,
//     following A=3,B=4 -> sum=7.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared widths, slice count and FSM state type for the operand adder
package adder_pkg;
    localparam int WIDTH  = 381;
    localparam int SLICE  = 64;
    localparam int SLICES = (WIDTH + SLICE - 1) / SLICE;
    localparam int PAD    = SLICES * SLICE;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        WAIT_A,
        WAIT_B,
        ADD,
        HOLD
    } state_t;
endpackage

// File: rtl/slice_adder.sv
// rtl/slice_adder.sv - combinational W-bit adder with carry in/out, one slice per cycle
module slice_adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/operand_add_sequencer.sv
// rtl/operand_add_sequencer.sv - captures A then B on rx_done edges, adds slice-serially, holds sum until accepted
// Optional WAIT_B watchdog enabled by defining ADDER_TIMEOUT_EN.
module operand_add_sequencer
    import adder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_done,
    output logic [WIDTH:0]   sum,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             busy,
    output logic             overrun,
    output logic             timeout
);
    state_t state, state_next;
    logic   done_q;
    logic   rx_edge;
    logic   [PAD-1:0] a_q, b_q, res_q;
    logic   carry_q;
    idx_t   idx_q;
    logic   [SLICE-1:0] s_slice;
    logic   c_out;
    logic   [PAD:0] full_sum;
    logic   cap_a, cap_b, step, finish, drop_a, tmo_hit;

    assign rx_edge   = rx_done & ~done_q;
    assign sum_valid = (state == HOLD);
    assign busy      = (state == ADD) || (state == HOLD);

    // Operands shift down one slice per cycle; results shift in from the top,
    // so after the last slice res_q holds every earlier slice in order.
    slice_adder #(.W(SLICE)) u_slice_adder (
        .a    (a_q[SLICE-1:0]),
        .b    (b_q[SLICE-1:0]),
        .cin  (carry_q),
        .s    (s_slice),
        .cout (c_out)
    );

    // Operands are zero-padded, so the true carry lands at bit WIDTH of the
    // padded sum; taking [WIDTH:0] is correct whether or not padding exists.
    assign full_sum = {c_out, s_slice, res_q[PAD-1:SLICE]};

`ifdef ADDER_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_hit = (state == WAIT_B) && !rx_edge && (tmo_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset || state != WAIT_B) tmo_cnt <= '0;
        else                          tmo_cnt <= tmo_cnt + 32'd1;
    end
`else
    logic unused_tmo;

    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        drop_a     = 1'b0;
        case (state)
            WAIT_A: if (rx_edge) begin
                cap_a      = 1'b1;
                state_next = WAIT_B;
            end
            WAIT_B: if (rx_edge) begin
                cap_b      = 1'b1;
                state_next = ADD;
            end else if (tmo_hit) begin
                drop_a     = 1'b1;
                state_next = WAIT_A;
            end
            ADD: begin
                step = 1'b1;
                if (idx_q == idx_t'(SLICES - 1)) begin
                    finish     = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: if (sum_ready) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WAIT_A;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum     <= '0;
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            done_q  <= rx_done;
            overrun <= rx_edge && busy;
            timeout <= tmo_hit;
            if (cap_a)  a_q <= PAD'(rx_data);
            if (drop_a) a_q <= '0;
            if (cap_b) begin
                b_q     <= PAD'(rx_data);
                carry_q <= 1'b0;
                idx_q   <= '0;
            end
            if (step) begin
                a_q     <= a_q >> SLICE;
                b_q     <= b_q >> SLICE;
                res_q   <= {s_slice, res_q[PAD-1:SLICE]};
                carry_q <= c_out;
                idx_q   <= idx_q + 1'b1;
            end
            if (finish) sum <= full_sum[WIDTH:0];
        end
    end
endmodule

// File: tb/tb_operand_add_sequencer.sv
// tb/tb_operand_add_sequencer.sv - directed self-checking bench for operand_add_sequencer
module tb_operand_add_sequencer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [380:0] rx_data = '0;
    logic         rx_done = 1'b0;
    logic [381:0] sum;
    logic         sum_valid;
    logic         sum_ready = 1'b0;
    logic         busy;
    logic         overrun;
    logic         timeout;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int tmo_cnt = 0;

    operand_add_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .sum       (sum),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .busy      (busy),
        .overrun   (overrun),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (overrun) ovr_cnt++;
            if (timeout) tmo_cnt++;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [380:0] d);
        @(posedge clk); #1;
        rx_data = d;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic wait_sum(output int n);
        n = 0;
        while (!sum_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic accept(input string tag);
        sum_ready = 1'b1;
        @(posedge clk); #1;
        sum_ready = 1'b0;
        check({tag, "_valid_drop"}, sum_valid, 1'b0);
    endtask

    task automatic add_pair(input string tag, input logic [380:0] a, input logic [380:0] b,
                            input logic [381:0] exp);
        int n;
        send(a);
        send(b);
        check({tag, "_busy"}, busy, 1'b1);
        wait_sum(n);
        // rx_done for B rose one clock before the capture edge returned by send
        check({tag, "_latency"}, n + 1, 7);
        check({tag, "_sum"}, sum, exp);
        accept(tag);
    endtask

    initial begin
        logic [381:0] e;
        logic [380:0] ones;
        int n;
        int ovr0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sum", sum, 0);
        check("rst_valid", sum_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        reset = 1'b0;

        add_pair("t1", 381'd1, 381'd2, 382'd3);

        ones = '1;
        e = 382'd1 << 381;
        add_pair("t2", ones, 381'd1, e);

        e = 382'd1 << 64;
        add_pair("t3", {317'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 381'd1, e);

        // stall in HOLD with an operand edge arriving mid-stall
        ovr0 = ovr_cnt;
        send(381'd10);
        send(381'd20);
        wait_sum(n);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                rx_data = 381'd999;
                rx_done = 1'b1;
            end else begin
                rx_done = 1'b0;
            end
            @(posedge clk); #1;
            check("t4_hold_sum", sum, 382'd30);
            check("t4_hold_valid", sum_valid, 1'b1);
        end
        accept("t4");
        check("t4_overrun_once", ovr_cnt - ovr0, 1);
        add_pair("t4_next", 381'd100, 381'd200, 382'd300);

        // edge in the same cycle the sum is accepted
        send(381'd1);
        send(381'd1);
        wait_sum(n);
        rx_data   = 381'd777;
        rx_done   = 1'b1;
        sum_ready = 1'b1;
        @(posedge clk); #1;
        sum_ready = 1'b0;
        rx_done   = 1'b0;
        check("t4b_valid", sum_valid, 1'b0);
        check("t4b_overrun", overrun, 1'b1);
        @(posedge clk); #1;
        check("t4b_overrun_end", overrun, 1'b0);
        add_pair("t4b_next", 381'd4, 381'd5, 382'd9);

        // reset while slices are being added
        send(381'd50);
        send(381'd60);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t5_valid", sum_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_sum", sum, 0);
        repeat (8) @(posedge clk);
        #1;
        check("t5_still_idle", sum_valid, 1'b0);
        add_pair("t5_next", 381'd5, 381'd7, 382'd12);

`ifdef ADDER_TIMEOUT_EN
        send(381'd9);
        n = 0;
        while (!timeout && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_timeout_cycle", n, 100);
        @(posedge clk); #1;
        check("t6_timeout_pulse", timeout, 1'b0);
        check("t6_timeout_count", tmo_cnt, 1);
        add_pair("t6_next", 381'd3, 381'd4, 382'd7);
`else
        send(381'd3);
        repeat (150) @(posedge clk);
        #1;
        check("t6_no_timeout", tmo_cnt, 0);
        check("t6_waiting", busy, 1'b0);
        send(381'd4);
        wait_sum(n);
        check("t6_latency", n + 1, 7);
        check("t6_sum", sum, 382'd7);
        accept("t6");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
